fc_neuron_seq: RTL and testbench
================================

Name: fc_neuron_seq

Overview:
- Time-multiplexed, parametrised fully-connected neuron: one output per inference, IN inputs streamed LANES per beat.
- Weights and bias are held in a loadable register file, so one instance serves any neuron without regeneration.
- Datapath per beat: signed multiply, lane adder tree, accumulate. At the end it adds the bias and applies ReLU.
- Successor to the fixed-weight combinational fc layer. Sits between the feature-vector stream and the next layer's input buffer.

Parameters:
- WIDTH, 8, signed bit width of inputs and weights.
- IN, 128, inputs per inference; must be a multiple of LANES.
- LANES, 4, inputs consumed per accepted beat; power of two, 1..16.
- OUT_W, 2*WIDTH+$clog2(IN)+1, output/accumulator width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  LANES*WIDTH  packed signed inputs; lane k at bits [k*WIDTH +: WIDTH].
- w_we  input  1  weight write strobe.
- w_addr  input  $clog2(IN)  weight index.
- w_data  input  WIDTH  signed weight value.
- b_we  input  1  bias write strobe.
- b_data  input  2*WIDTH  signed bias value.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  OUT_W  signed result.

Behaviour:
- Reset: state IDLE; beat counter 0; accumulator 0; pipeline valids 0; out_valid 0; out_data 0. Weight and bias registers are cleared to 0. in_ready is 1 on the first cycle after reset.
- Beat accept: in_valid && in_ready. Beat n (0-based) multiplies lane k by weight[n*LANES+k].
- States and transitions:
  - IDLE: in_ready=1; first accepted beat -> ACC.
  - ACC: in_ready=1; accepting beat IN/LANES-1 -> DRAIN.
  - DRAIN: in_ready=0; waits until the pipeline is empty, then -> OUT.
  - OUT: in_ready=0; out_valid=1; out_valid && out_ready -> IDLE.
- Pipeline timing:
  - Accepted at cycle t: LANES products plus lane tree registered at t+1; accumulator updated at t+2.
  - If the last beat is accepted at cycle t, out_data = acc + sext(bias), post-ReLU, is registered with out_valid=1 at t+3.
  - Total latency, last beat to out_valid: 3 cycles.
- Arithmetic:
  - All multiplies and adds are signed. Products are 2*WIDTH bits; the lane sum is 2*WIDTH+$clog2(LANES) bits, sign-extended into OUT_W.
  - OUT_W covers the worst case (-2^(WIDTH-1))^2*IN + bias; no overflow and no saturation.
- Accumulator reload:
  - The accumulator clears when the first beat's lane sum lands; it is not cleared on the OUT->IDLE transition.
  - Back-to-back inferences therefore need no idle cycle beyond the OUT handshake.
- Backpressure: in OUT, out_data and out_valid hold stable until out_ready. in_valid is ignored while in_ready=0.
- Weight and bias writes:
  - Honoured only in IDLE with no beat in flight.
  - Writes in any other state, or in the same cycle as an accepted beat, are dropped silently.
- Simultaneous w_we and b_we in IDLE: both are applied.
- Reset mid-inference: the partial sum is discarded and out_valid drops on the next edge. Weights and bias are cleared.
- Beat counter wrap: returns to 0 when moving to DRAIN.

Optional Feature:
- Macro: FC_NEURON_RELU_EN.
- Defined: output = (sum < 0) ? 0 : sum.
- Undefined: output is the raw signed sum, bias included. Everything else is identical, including latency.

Test Plan:
1. IN=128, LANES=4; all weights 1, bias 0, all inputs 1 -> out_data=128, out_valid exactly 3 cycles after the 32nd accepted beat.
2. All weights -1, bias 0, inputs 1 -> 0 with FC_NEURON_RELU_EN; -128 (two's complement in OUT_W) without it.
3. All weights and inputs -128, bias 0x7FFF -> 2097152+32767 = 2129919; no wrap in OUT_W=24.
4. Hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0 throughout. Then out_ready=1 -> next inference accepted on the following cycle and its result is independent of the previous one.
5. w_we pulse for weight 5 -> 7 during ACC -> weight 5 unchanged (verified via a one-hot input pattern in the next inference). The same write in IDLE takes effect.
6. Assert rst after 10 beats -> out_valid stays 0, in_ready=1 next cycle. A fresh inference with reloaded weights gives the correct sum.

Source files
------------

// File: rtl/fc_neuron_seq_if.sv
// Stream, weight-load and result handshake bundle for fc_neuron_seq.
interface fc_neuron_seq_if #(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int LANES = 4
);
  localparam int OUT_W = 2*WIDTH + $clog2(IN) + 1;
  localparam int AW    = $clog2(IN);

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   w_we;
  logic [AW-1:0]          w_addr;
  logic [WIDTH-1:0]       w_data;
  logic                   b_we;
  logic [2*WIDTH-1:0]     b_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;

  modport master (
    output in_valid, in_data, w_we, w_addr, w_data, b_we, b_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, w_we, w_addr, w_data, b_we, b_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fc_neuron_seq.sv
// Time-multiplexed fully-connected neuron: LANES MACs per beat, loadable weights/bias.
// Define FC_NEURON_RELU_EN to clamp negative results to zero; otherwise the raw sum is output.
module fc_neuron_seq #(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int LANES = 4
) (
  input logic           clk,
  input logic           rst,
  fc_neuron_seq_if.slave bus
);
  localparam int OUT_W  = 2*WIDTH + $clog2(IN) + 1;
  localparam int AW     = $clog2(IN);
  localparam int BEATS  = IN / LANES;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PROD_W = 2*WIDTH;
  localparam int SUM_W  = 2*WIDTH + $clog2(LANES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
  logic                     s1_valid_q, s1_first_q, s1_last_q;
  logic signed [SUM_W-1:0]  sum_q;
  logic                     s2_valid_q, s2_last_q;
  logic signed [OUT_W-1:0]  acc_q, acc_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic signed [WIDTH-1:0]  weights_q [IN];
  logic signed [2*WIDTH-1:0] bias_q;

  logic                     in_ready;
  logic                     accept;
  logic                     last_beat;
  logic                     cfg_wr_en;
  logic [AW-1:0]            beat_base;
  logic signed [PROD_W-1:0] prod [LANES];
  logic signed [SUM_W-1:0]  lane_sum;
  logic signed [OUT_W-1:0]  sum_ext, bias_ext, total;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACC);
  assign accept    = bus.in_valid && in_ready;
  assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));
  // Config writes only land while nothing is moving through the datapath.
  assign cfg_wr_en = (state_q == S_IDLE) && !accept && !s1_valid_q && !s2_valid_q;
  assign beat_base = AW'(beat_cnt_q) * AW'(LANES);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [AW-1:0] idx;
    assign idx     = beat_base + AW'(k);
    assign prod[k] = $signed(bus.in_data[k*WIDTH +: WIDTH]) * weights_q[idx];
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) lane_sum = lane_sum + SUM_W'(prod[k]);
  end

  assign sum_ext  = OUT_W'(sum_q);
  assign bias_ext = OUT_W'(bias_q);
  assign total    = acc_q + bias_ext;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      S_IDLE, S_ACC: begin
        if (accept) begin
          if (last_beat) begin
            state_d    = S_DRAIN;
            beat_cnt_d = '0;
          end else begin
            state_d    = S_ACC;
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: if (s2_last_q) state_d = S_OUT;
      S_OUT:   if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    // First lane sum of an inference overwrites the stale total from the previous one.
    if (s1_valid_q) acc_d = s1_first_q ? sum_ext : acc_q + sum_ext;
    if (s2_last_q) begin
      out_valid_d = 1'b1;
`ifdef FC_NEURON_RELU_EN
      out_data_d  = total[OUT_W-1] ? '0 : total;
`else
      out_data_d  = total;
`endif
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      sum_q       <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      s1_valid_q  <= accept;
      s1_first_q  <= accept && (state_q == S_IDLE);
      s1_last_q   <= accept && last_beat;
      if (accept) sum_q <= lane_sum;
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_valid_q && s1_last_q;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the weight file is reset deliberately; a reset neuron must compute with all-zero weights.
    if (rst) begin
      for (int i = 0; i < IN; i++) weights_q[i] <= '0;
      bias_q <= '0;
    end else if (cfg_wr_en) begin
      if (bus.w_we) weights_q[bus.w_addr] <= bus.w_data;
      if (bus.b_we) bias_q <= bus.b_data;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_fc_neuron_seq.sv
// Directed self-checking bench for fc_neuron_seq (IN=128, LANES=4, WIDTH=8).
module tb_fc_neuron_seq;
  localparam int WIDTH = 8;
  localparam int IN    = 128;
  localparam int LANES = 4;
  localparam int BEATS = IN / LANES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic signed [WIDTH-1:0] x [IN];

  fc_neuron_seq_if #(.WIDTH(WIDTH), .IN(IN), .LANES(LANES)) bus ();

  fc_neuron_seq #(.WIDTH(WIDTH), .IN(IN), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_all_w(input logic [WIDTH-1:0] v);
    for (int i = 0; i < IN; i++) begin
      bus.w_we   = 1'b1;
      bus.w_addr = 7'(i);
      bus.w_data = v;
      tick();
    end
    bus.w_we = 1'b0;
  endtask

  task automatic write_w(input int addr, input logic [WIDTH-1:0] v);
    bus.w_we = 1'b1; bus.w_addr = 7'(addr); bus.w_data = v;
    tick();
    bus.w_we = 1'b0;
  endtask

  task automatic write_b(input logic [2*WIDTH-1:0] v);
    bus.b_we = 1'b1; bus.b_data = v;
    tick();
    bus.b_we = 1'b0;
  endtask

  task automatic set_x(input logic signed [WIDTH-1:0] v);
    for (int i = 0; i < IN; i++) x[i] = v;
  endtask

  task automatic drive_beat(input int b);
    for (int k = 0; k < LANES; k++) bus.in_data[k*WIDTH +: WIDTH] = x[b*LANES + k];
    bus.in_valid = 1'b1;
  endtask

  // Streams x; inj_beat >= 0 also pulses a weight-5 := 7 write during that beat.
  task automatic run_inf(input string tag, input int inj_beat, input logic [31:0] exp);
    int lat;
    check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    for (int b = 0; b < BEATS; b++) begin
      drive_beat(b);
      if (b == inj_beat) begin
        bus.w_we = 1'b1; bus.w_addr = 7'd5; bus.w_data = 8'sd7;
      end
      tick();
      bus.w_we = 1'b0;
    end
    bus.in_valid = 1'b0;
    check({tag, "_in_ready_drain"}, 32'(bus.in_ready), 32'd0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_data"}, 32'(bus.out_data), exp);
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_hs_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_hs_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.w_we = 1'b0; bus.w_addr = '0;
    bus.w_data = '0; bus.b_we = 1'b0; bus.b_data = '0; bus.out_ready = 1'b0;
    set_x(8'sd1);

    // Reset state
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    run_inf("t0_cleared_w", -1, 32'd0);
    handshake("t0");

    // 1: all ones
    write_all_w(8'sd1);
    run_inf("t1_ones", -1, 32'd128);
    handshake("t1");

    // 2: weights -1
    write_all_w(-8'sd1);
`ifdef FC_NEURON_RELU_EN
    run_inf("t2_neg", -1, 32'd0);
`else
    run_inf("t2_neg", -1, 32'h00FF_FF80);
`endif
    handshake("t2");

    // 3: worst-case magnitude plus max bias
    write_all_w(-8'sd128);
    write_b(16'h7FFF);
    set_x(-8'sd128);
    run_inf("t3_max", -1, 32'h0020_7FFF);

    // 4: backpressure with junk beats offered in OUT
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'($urandom);
      tick();
      check("t4_hold_data", 32'(bus.out_data), 32'h0020_7FFF);
      check("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    handshake("t4");
    set_x(8'sd1);
    run_inf("t4_next", -1, 32'd16383);
    handshake("t4n");

    // 5: weight writes outside IDLE-without-beat are dropped
    write_all_w(8'sd0);
    write_b(16'h0000);
    write_w(5, 8'sd3);
    set_x(8'sd0);
    x[5] = 8'sd1;
    run_inf("t5_acc_write", 10, 32'd3);
    handshake("t5a");
    run_inf("t5_beat_write", 0, 32'd3);
    write_w(5, 8'sd7);
    handshake("t5b");
    run_inf("t5_out_write", -1, 32'd3);
    handshake("t5c");
    bus.w_we = 1'b1; bus.w_addr = 7'd5; bus.w_data = 8'sd7;
    bus.b_we = 1'b1; bus.b_data = 16'd100;
    tick();
    bus.w_we = 1'b0; bus.b_we = 1'b0;
    run_inf("t5_idle_write", -1, 32'd107);
    handshake("t5d");

    // 6: reset mid-inference
    for (int b = 0; b < 10; b++) begin
      drive_beat(b);
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_in_ready", 32'(bus.in_ready), 32'd1);
    for (int c = 0; c < 5; c++) begin
      check("t6_no_valid", 32'(bus.out_valid), 32'd0);
      tick();
    end
    set_x(8'sd1);
    run_inf("t6_cleared", -1, 32'd0);
    handshake("t6a");
    write_all_w(8'sd2);
    write_b(16'd20);
    for (int i = 0; i < IN; i++) x[i] = 8'((i % 7) - 3);
    run_inf("t6_reload", -1, 32'd10);
    handshake("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
